// File: rtl/uart_rx_ovs_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ovs_pkg
//   Shared definitions for the oversampling UART receiver: FSM state encoding,
//   parity configuration codes and small helper functions.
//   Data-bit codes: 2'b00=5, 2'b01=6, 2'b10=7, 2'b11=8 data bits.
//   Parity codes:   2'b01=odd, 2'b10=even, 2'b00/2'b11=none.
// -----------------------------------------------------------------------------
package uart_rx_ovs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Number of data bits encoded by a cfg_databits code.
    function automatic logic [3:0] data_len(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    // True when the parity code selects odd or even parity.
    function automatic logic parity_on(input logic [1:0] code);
        return (code == PAR_ODD) || (code == PAR_EVEN);
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Down-counter producing the oversample tick. The counter starts from div,
//   raises tick for one clock when it reaches zero and then reloads. A reload
//   request restarts the period immediately so the bit phase can be aligned to
//   an external event. div=0 gives a tick on every clock.
// Ports
//   clk     in   1  clock
//   rst_n   in   1  asynchronous active-low reset (counter loads div)
//   div     in   W  tick period in clk cycles minus 1
//   reload  in   1  restart the period from div
//   tick    out  1  one-clock tick when the counter is zero
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] div,
    input  logic         reload,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= div;
        end else if (reload || tick) begin
            cnt <= div;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// -----------------------------------------------------------------------------
// uart_rx_ovs
//   Oversampling UART receiver. Each bit is split into OVS ticks; the line is
//   sampled at ticks OVS/2-1, OVS/2 and OVS/2+1 and the bit value is the
//   majority of the three. Supports 5..8 data bits, none/odd/even parity and
//   one or two stop bits, with framing, parity, overrun and break detection.
//   Configuration is captured at the start edge and held for the whole frame.
//
//   Output handshake: fifo_w_en is a one-clock write strobe with no ready
//   return. fifo_full is sampled when a frame completes; if it is high the
//   word is dropped and err_overrun pulses in the cycle the strobe would have
//   fired. rx_data/err_frame/err_parity change only on a write and hold until
//   the next one.
// Ports
//   glb_clk, glb_rstn  clock, asynchronous active-low reset
//   cfg_rx_en          receiver enable; low forces IDLE on the next clock
//   cfg_databits       data-bit code (5..8)
//   cfg_paritybit      parity code (none/odd/even)
//   cfg_stopbit        0 = 1 stop bit, 1 = 2 stop bits
//   cfg_baud_div       tick period in clocks minus 1
//   usr_data_rcvbit    asynchronous serial input, idle high
//   fifo_full          Rx FIFO full
//   rx_data            received word, LSB aligned, unused upper bits zero
//   fifo_w_en          one-clock FIFO write strobe
//   err_frame          stop bit sampled 0 (valid with fifo_w_en)
//   err_parity         parity mismatch (valid with fifo_w_en)
//   err_overrun        one-clock pulse: completed word dropped, FIFO full
//   rx_break           one-clock pulse: break condition detected
//   rx_busy            state is not IDLE
//   dbg_state          current FSM state encoding
// -----------------------------------------------------------------------------
module uart_rx_ovs
    import uart_rx_ovs_pkg::*;
#(
    parameter int OVS     = 16,
    parameter int PRESC_W = 16
) (
    input  logic               glb_clk,
    input  logic               glb_rstn,
    input  logic               cfg_rx_en,
    input  logic [1:0]         cfg_databits,
    input  logic [1:0]         cfg_paritybit,
    input  logic               cfg_stopbit,
    input  logic [PRESC_W-1:0] cfg_baud_div,
    input  logic               usr_data_rcvbit,
    input  logic               fifo_full,
    output logic [7:0]         rx_data,
    output logic               fifo_w_en,
    output logic               err_frame,
    output logic               err_parity,
    output logic               err_overrun,
    output logic               rx_break,
    output logic               rx_busy,
    output logic [2:0]         dbg_state
);

    localparam int IDX_W = $clog2(OVS);
    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVS/2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVS/2);
    localparam logic [IDX_W-1:0] IDX_S2   = IDX_W'(OVS/2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);

    rx_state_e state;

    // Line synchronizer plus one extra stage for edge detection.
    logic sync1, sync2, line_prev;
    logic fall;

    // Bit timing.
    logic               tick;
    logic [IDX_W-1:0]   tick_idx;
    logic [PRESC_W-1:0] div_q;
    logic [PRESC_W-1:0] div_sel;
    logic               start_det;
    logic               samp0, samp1;
    logic               voted;
    logic               vote_tick;

    // Frame configuration captured at the start edge.
    logic [3:0] nbits_q;
    logic [1:0] par_q;
    logic       sb_q;

    // Frame accumulation.
    logic [3:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_acc;
    logic             par_bad;
    logic             all_zero;
    logic             frame_bad;
    logic             stop_cnt;
    logic             stop_bad;
    logic [IDX_W-1:0] hi_cnt;

    assign fall      = line_prev & ~sync2;
    assign start_det = (state == ST_IDLE) && cfg_rx_en && fall;
    // While idle follow the live divisor; inside a frame use the captured one.
    assign div_sel   = (state == ST_IDLE) ? cfg_baud_div : div_q;
    // The third sample is the live synchronized line at the final vote tick.
    assign voted     = maj3(samp0, samp1, sync2);
    assign vote_tick = tick && (tick_idx == IDX_S2);
    assign stop_bad  = frame_bad | ~voted;
    assign rx_busy   = (state != ST_IDLE);
    assign dbg_state = state;

    uart_baud_tick #(
        .W (PRESC_W)
    ) u_tick (
        .clk    (glb_clk),
        .rst_n  (glb_rstn),
        .div    (div_sel),
        .reload (start_det),
        .tick   (tick)
    );

    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            state       <= ST_IDLE;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            line_prev   <= 1'b1;
            tick_idx    <= '0;
            samp0       <= 1'b1;
            samp1       <= 1'b1;
            div_q       <= '0;
            nbits_q     <= 4'd8;
            par_q       <= 2'b00;
            sb_q        <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            par_bad     <= 1'b0;
            all_zero    <= 1'b0;
            frame_bad   <= 1'b0;
            stop_cnt    <= 1'b0;
            hi_cnt      <= '0;
            rx_data     <= '0;
            fifo_w_en   <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
            rx_break    <= 1'b0;
        end else begin
            fifo_w_en   <= 1'b0;
            err_overrun <= 1'b0;
            rx_break    <= 1'b0;

            sync1     <= usr_data_rcvbit;
            sync2     <= sync1;
            line_prev <= sync2;

            // Tick index restarts at the start edge so that index 0 is the
            // first tick after the falling edge.
            if (start_det) begin
                tick_idx <= '0;
            end else if (tick) begin
                tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
            end

            if (tick && (tick_idx == IDX_S0)) samp0 <= sync2;
            if (tick && (tick_idx == IDX_S1)) samp1 <= sync2;

            if (!cfg_rx_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall) begin
                            state     <= ST_START;
                            div_q     <= cfg_baud_div;
                            nbits_q   <= data_len(cfg_databits);
                            par_q     <= cfg_paritybit;
                            sb_q      <= cfg_stopbit;
                            bit_cnt   <= '0;
                            shreg     <= '0;
                            par_acc   <= 1'b0;
                            par_bad   <= 1'b0;
                            all_zero  <= 1'b1;
                            frame_bad <= 1'b0;
                            stop_cnt  <= 1'b0;
                        end
                    end

                    ST_START: begin
                        if (vote_tick) begin
                            state <= voted ? ST_IDLE : ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        if (vote_tick) begin
                            shreg[bit_cnt[2:0]] <= voted;
                            par_acc             <= par_acc ^ voted;
                            all_zero            <= all_zero & ~voted;
                            bit_cnt             <= bit_cnt + 4'd1;
                            if (bit_cnt == nbits_q - 4'd1) begin
                                state <= parity_on(par_q) ? ST_PARITY : ST_STOP;
                            end
                        end
                    end

                    ST_PARITY: begin
                        if (vote_tick) begin
                            // Even: parity bit equals XOR of data; odd: its inverse.
                            par_bad  <= voted ^ (par_acc ^ (par_q == PAR_ODD));
                            all_zero <= all_zero & ~voted;
                            state    <= ST_STOP;
                        end
                    end

                    ST_STOP: begin
                        if (vote_tick) begin
                            if (!stop_cnt && !voted && all_zero) begin
                                rx_break <= 1'b1;
                                hi_cnt   <= '0;
                                state    <= ST_WAIT_IDLE;
                            end else if (!stop_cnt && sb_q) begin
                                frame_bad <= stop_bad;
                                stop_cnt  <= 1'b1;
                            end else begin
                                // Frame complete at the mid-sample of the last stop bit.
                                if (fifo_full) begin
                                    err_overrun <= 1'b1;
                                end else begin
                                    fifo_w_en  <= 1'b1;
                                    rx_data    <= shreg;
                                    err_frame  <= stop_bad;
                                    err_parity <= par_bad;
                                end
                                hi_cnt <= '0;
                                state  <= stop_bad ? ST_WAIT_IDLE : ST_IDLE;
                            end
                        end
                    end

                    ST_WAIT_IDLE: begin
                        // Require OVS consecutive high ticks (one bit time).
                        if (tick) begin
                            if (!sync2) begin
                                hi_cnt <= '0;
                            end else if (hi_cnt == IDX_LAST) begin
                                state <= ST_IDLE;
                            end else begin
                                hi_cnt <= hi_cnt + 1'b1;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
module tb_uart_rx_ovs;

  localparam int OVS     = 16;
  localparam int PRESC_W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd5;

  // ---------------- clock / reset ----------------
  logic glb_clk = 1'b0;
  logic glb_rstn;
  always #5 glb_clk = ~glb_clk;

  logic               cfg_rx_en;
  logic [1:0]         cfg_databits;
  logic [1:0]         cfg_paritybit;
  logic               cfg_stopbit;
  logic [PRESC_W-1:0] cfg_baud_div;
  logic               usr_data_rcvbit;
  logic               fifo_full;
  logic [7:0]         rx_data;
  logic               fifo_w_en;
  logic               err_frame;
  logic               err_parity;
  logic               err_overrun;
  logic               rx_break;
  logic               rx_busy;
  logic [2:0]         dbg_state;

  uart_rx_ovs #(.OVS(OVS), .PRESC_W(PRESC_W)) dut (
    .glb_clk         (glb_clk),
    .glb_rstn        (glb_rstn),
    .cfg_rx_en       (cfg_rx_en),
    .cfg_databits    (cfg_databits),
    .cfg_paritybit   (cfg_paritybit),
    .cfg_stopbit     (cfg_stopbit),
    .cfg_baud_div    (cfg_baud_div),
    .usr_data_rcvbit (usr_data_rcvbit),
    .fifo_full       (fifo_full),
    .rx_data         (rx_data),
    .fifo_w_en       (fifo_w_en),
    .err_frame       (err_frame),
    .err_parity      (err_parity),
    .err_overrun     (err_overrun),
    .rx_break        (rx_break),
    .rx_busy         (rx_busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int bit_cyc = 64;

  logic [9:0] exp_q[$];          // {err_frame, err_parity, rx_data}
  logic [9:0] got_mem [0:255];
  int wr_cnt   = 0;
  int ovr_cnt  = 0;
  int brk_cnt  = 0;
  int busy_cnt = 0;
  int rd_idx   = 0;

  // Monitor: records DUT activity on the falling edge.
  always @(negedge glb_clk) begin
    if (glb_rstn) begin
      if (fifo_w_en) begin
        got_mem[wr_cnt[7:0]] = {err_frame, err_parity, rx_data};
        wr_cnt = wr_cnt + 1;
      end
      if (err_overrun) ovr_cnt = ovr_cnt + 1;
      if (rx_break) brk_cnt = brk_cnt + 1;
      if (rx_busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    logic [9:0] e;
    while (exp_q.size() > 0 && rd_idx < wr_cnt) begin
      e = exp_q.pop_front();
      check(name, {22'd0, got_mem[rd_idx[7:0]]}, {22'd0, e});
      rd_idx++;
    end
    rd_idx = wr_cnt;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic v);
    usr_data_rcvbit = v;
    repeat (bit_cyc) @(posedge glb_clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    usr_data_rcvbit = 1'b1;
    repeat (n * bit_cyc) @(posedge glb_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nb, input logic [1:0] par,
                            input logic sb, input logic flip, input logic s1, input logic s2);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      send_bit(data[i]);
      p = p ^ data[i];
    end
    if (par == 2'b01 || par == 2'b10) begin
      if (par == 2'b01) p = ~p;
      send_bit(p ^ flip);
    end
    send_bit(s1);
    if (sb) send_bit(s2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] db;
    logic [1:0] par;
    logic       sb;
    logic [7:0] data;
    logic       flip;
    logic       s1;
    logic       s2;
    logic       full;
    logic       exp_wr;
    logic [9:0] exp_word;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int wr_b, ovr_b, brk_b, busy_b;

    vecs[0] = '{db:2'd3, par:2'd0, sb:1'b0, data:8'hA5, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h0A5, exp_ovr:1'b0};
    vecs[1] = '{db:2'd2, par:2'd2, sb:1'b0, data:8'h35, flip:1'b1, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h135, exp_ovr:1'b0};
    vecs[2] = '{db:2'd3, par:2'd0, sb:1'b1, data:8'h5A, flip:1'b0, s1:1'b1, s2:1'b0, full:1'b0, exp_wr:1'b1, exp_word:10'h25A, exp_ovr:1'b0};
    vecs[3] = '{db:2'd3, par:2'd0, sb:1'b0, data:8'h3C, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b1, exp_wr:1'b0, exp_word:10'h000, exp_ovr:1'b1};
    vecs[4] = '{db:2'd0, par:2'd1, sb:1'b0, data:8'h13, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h013, exp_ovr:1'b0};
    vecs[5] = '{db:2'd1, par:2'd2, sb:1'b1, data:8'h2D, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h02D, exp_ovr:1'b0};
    vecs[6] = '{db:2'd3, par:2'd1, sb:1'b0, data:8'h00, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h000, exp_ovr:1'b0};
    vecs[7] = '{db:2'd2, par:2'd0, sb:1'b0, data:8'hFF, flip:1'b0, s1:1'b1, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h07F, exp_ovr:1'b0};
    vecs[8] = '{db:2'd3, par:2'd0, sb:1'b0, data:8'hC3, flip:1'b0, s1:1'b0, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h2C3, exp_ovr:1'b0};
    vecs[9] = '{db:2'd3, par:2'd2, sb:1'b1, data:8'h81, flip:1'b1, s1:1'b0, s2:1'b1, full:1'b0, exp_wr:1'b1, exp_word:10'h381, exp_ovr:1'b0};

    // ---- reset ----
    glb_rstn        = 1'b0;
    cfg_rx_en       = 1'b1;
    cfg_databits    = 2'd3;
    cfg_paritybit   = 2'd0;
    cfg_stopbit     = 1'b0;
    cfg_baud_div    = 16'd3;
    usr_data_rcvbit = 1'b1;
    fifo_full       = 1'b0;
    bit_cyc         = 64;
    repeat (5) @(posedge glb_clk);
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_outputs", {26'd0, fifo_w_en, err_frame, err_parity, err_overrun, rx_break, rx_busy}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    glb_rstn = 1'b1;
    repeat (10) @(posedge glb_clk);
    #1;

    // ---- break: line low 12 bit times, then a clean 0x55 ----
    wr_b = wr_cnt; brk_b = brk_cnt;
    usr_data_rcvbit = 1'b0;
    repeat (12 * bit_cyc) @(posedge glb_clk);
    #1;
    idle_bits(2);
    check("break_pulse", brk_cnt - brk_b, 1);
    check("break_no_write", wr_cnt - wr_b, 0);
    check("break_no_ferr", {31'd0, err_frame}, 0);
    check("break_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    wr_b = wr_cnt;
    exp_q.push_back(10'h055);
    send_frame(8'h55, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check("after_break_wr", wr_cnt - wr_b, 1);
    drain("after_break_word");

    // ---- table-driven frames ----
    for (int v = 0; v < 10; v++) begin
      cfg_databits  = vecs[v].db;
      cfg_paritybit = vecs[v].par;
      cfg_stopbit   = vecs[v].sb;
      fifo_full     = vecs[v].full;
      wr_b = wr_cnt; ovr_b = ovr_cnt; brk_b = brk_cnt;
      if (vecs[v].exp_wr) exp_q.push_back(vecs[v].exp_word);
      send_frame(vecs[v].data, 5 + int'(vecs[v].db), vecs[v].par, vecs[v].sb,
                 vecs[v].flip, vecs[v].s1, vecs[v].s2);
      idle_bits(2);
      fifo_full = 1'b0;
      check($sformatf("v%0d_wr_count", v), wr_cnt - wr_b, {31'd0, vecs[v].exp_wr});
      check($sformatf("v%0d_overrun", v), ovr_cnt - ovr_b, {31'd0, vecs[v].exp_ovr});
      check($sformatf("v%0d_break", v), brk_cnt - brk_b, 0);
      check($sformatf("v%0d_state", v), {29'd0, dbg_state}, {29'd0, S_IDLE});
      if (vecs[v].exp_wr)
        check($sformatf("v%0d_err_held", v), {30'd0, err_frame, err_parity}, {30'd0, vecs[v].exp_word[9:8]});
      drain($sformatf("v%0d_word", v));
    end

    // ---- glitch on idle line: ~0.3 bit low ----
    cfg_databits = 2'd3; cfg_paritybit = 2'd0; cfg_stopbit = 1'b0;
    wr_b = wr_cnt; busy_b = busy_cnt;
    usr_data_rcvbit = 1'b0;
    repeat (19) @(posedge glb_clk);
    #1;
    idle_bits(2);
    check("glitch_busy_pulse", {31'd0, (busy_cnt - busy_b > 0) && (busy_cnt - busy_b < bit_cyc)}, 1);
    check("glitch_no_write", wr_cnt - wr_b, 0);
    check("glitch_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

    // ---- 8N2 second stop bit low: WAIT_IDLE dwell ----
    cfg_stopbit = 1'b1;
    wr_b = wr_cnt;
    exp_q.push_back(10'h25A);
    send_frame(8'h5A, 8, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    usr_data_rcvbit = 1'b1;
    check("ferr_wait_state", {29'd0, dbg_state}, {29'd0, S_WAIT});
    repeat (bit_cyc / 2) @(posedge glb_clk);
    #1;
    check("ferr_wait_half", {29'd0, dbg_state}, {29'd0, S_WAIT});
    repeat (bit_cyc * 3 / 2) @(posedge glb_clk);
    #1;
    check("ferr_wait_done", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("ferr_wr_count", wr_cnt - wr_b, 1);
    drain("ferr_word");
    cfg_stopbit = 1'b0;

    // ---- receiver disabled mid-DATA ----
    wr_b = wr_cnt; ovr_b = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("en_drop_in_data", {29'd0, dbg_state}, {29'd0, S_DATA});
    cfg_rx_en = 1'b0;
    @(posedge glb_clk);
    #1;
    check("en_drop_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cfg_rx_en = 1'b1;
    idle_bits(2);
    check("en_drop_no_write", wr_cnt - wr_b, 0);
    check("en_drop_no_ovr", ovr_cnt - ovr_b, 0);

    // ---- max rate: div=0, back-to-back 8N1 frames ----
    cfg_baud_div = 16'd0;
    bit_cyc = 16;
    idle_bits(2);
    wr_b = wr_cnt;
    exp_q.push_back(10'h096);
    exp_q.push_back(10'h069);
    send_frame(8'h96, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h69, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    check("b2b_wr_count", wr_cnt - wr_b, 2);
    drain("b2b_word");
    check("b2b_busy_low", {31'd0, rx_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #5000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "time limit");
  end

endmodule
